// File: rtl/piso_serializer_stream.sv
// Parallel-in/serial-out shifter with a valid/ready word input and a one-word holding buffer.
// One bit advances per shift_en strobe; a held word reloads at the boundary with no gap bit.
module piso_serializer_stream #(
  parameter int N          = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   enable,
  input  logic                   shift_en,
  output logic                   serial_out,
  output logic                   send_ready,
  output logic                   word_done,
  output logic [$clog2(N+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t       state;
  logic [N-1:0] hold;
  logic         hold_full;
  logic [N-1:0] shift_reg;

  function automatic logic first_of(input logic [N-1:0] w);
    return MSB_FIRST ? w[N-1] : w[0];
  endfunction

  // The bit just driven is shifted out so the next one always sits at the head.
  function automatic logic [N-1:0] advance(input logic [N-1:0] w);
    return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
  endfunction

  assign data_ready = !hold_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      serial_out <= IDLE_LEVEL;
      send_ready <= 1'b0;
      word_done  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      word_done <= 1'b0;
      if (data_valid && !hold_full) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full && enable) begin
            shift_reg <= hold;
            hold_full <= 1'b0;
            state     <= ARMED;
          end
        end
        ARMED: begin
          if (shift_en) begin
            serial_out <= first_of(shift_reg);
            shift_reg  <= advance(shift_reg);
            send_ready <= 1'b1;
            bit_cnt    <= CW'(1);
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (bit_cnt != LAST) begin
              serial_out <= first_of(shift_reg);
              shift_reg  <= advance(shift_reg);
              bit_cnt    <= bit_cnt + CW'(1);
            end else begin
              word_done <= 1'b1;
              if (hold_full && enable) begin
                serial_out <= first_of(hold);
                shift_reg  <= advance(hold);
                hold_full  <= 1'b0;
                bit_cnt    <= CW'(1);
              end else begin
                serial_out <= IDLE_LEVEL;
                send_ready <= 1'b0;
                bit_cnt    <= '0;
                state      <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer_stream.sv
// Directed bench for piso_serializer_stream: three builds (8-bit MSB, 8-bit LSB, 16-bit MSB)
// share stimulus; a bit queue holds expected serial data pushed when words are offered.
module tb_piso_serializer_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        data_valid = 1'b0;
  logic        enable = 1'b1;
  logic        shift_en = 1'b0;
  logic [7:0]  data8 = '0;
  logic [15:0] data16 = '0;

  logic       ready_a, sout_a, sr_a, wd_a;
  logic [3:0] cnt_a;
  logic       ready_b, sout_b, sr_b, wd_b;
  logic [3:0] cnt_b;
  logic       ready_c, sout_c, sr_c, wd_c;
  logic [4:0] cnt_c;

  int sel = 0;
  logic       o_ready, o_sout, o_sr, o_wd;
  logic [4:0] o_cnt;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  piso_serializer_stream #(.N(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data8), .data_valid(data_valid), .data_ready(ready_a),
    .enable(enable), .shift_en(shift_en), .serial_out(sout_a), .send_ready(sr_a),
    .word_done(wd_a), .bit_cnt(cnt_a));

  piso_serializer_stream #(.N(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data8), .data_valid(data_valid), .data_ready(ready_b),
    .enable(enable), .shift_en(shift_en), .serial_out(sout_b), .send_ready(sr_b),
    .word_done(wd_b), .bit_cnt(cnt_b));

  piso_serializer_stream #(.N(16), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .data_in(data16), .data_valid(data_valid), .data_ready(ready_c),
    .enable(enable), .shift_en(shift_en), .serial_out(sout_c), .send_ready(sr_c),
    .word_done(wd_c), .bit_cnt(cnt_c));

  always_comb begin
    o_ready = ready_a; o_sout = sout_a; o_sr = sr_a; o_wd = wd_a; o_cnt = {1'b0, cnt_a};
    if (sel == 1) begin
      o_ready = ready_b; o_sout = sout_b; o_sr = sr_b; o_wd = wd_b; o_cnt = {1'b0, cnt_b};
    end else if (sel == 2) begin
      o_ready = ready_c; o_sout = sout_c; o_sr = sr_c; o_wd = wd_c; o_cnt = cnt_c;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sout"}, 16'(o_sout), 16'h1);
    chk({tag, "_sr"}, 16'(o_sr), 16'h0);
    chk({tag, "_wd"}, 16'(o_wd), 16'h0);
    chk({tag, "_cnt"}, 16'(o_cnt), 16'h0);
    chk({tag, "_ready"}, 16'(o_ready), 16'h1);
  endtask

  // Offer a word; queue its bits in send order when the caller expects it to be transmitted.
  task automatic push_word(input logic [15:0] w, input int n, input bit msb, input bit track);
    int budget = 50;
    while (!o_ready && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) chk("push_timeout", 16'(o_ready), 16'h1);
    data8 = w[7:0];
    data16 = w;
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    if (track)
      for (int i = 0; i < n; i++) exp_q.push_back(msb ? w[n-1-i] : w[i]);
  endtask

  task automatic strobe(input string tag, input bit exp_sr, input bit exp_wd, input int exp_cnt);
    logic b;
    shift_en = 1'b1;
    cyc();
    shift_en = 1'b0;
    chk({tag, "_wd"}, 16'(o_wd), 16'(exp_wd));
    chk({tag, "_sr"}, 16'(o_sr), 16'(exp_sr));
    chk({tag, "_cnt"}, 16'(o_cnt), 16'(exp_cnt));
    if (exp_sr) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_q_empty"}, 16'(exp_q.size()), 16'h1);
      end else begin
        b = exp_q.pop_front();
        chk({tag, "_bit"}, 16'(o_sout), 16'(b));
      end
    end else begin
      chk({tag, "_idle"}, 16'(o_sout), 16'h1);
    end
  endtask

  initial begin
    // 1: 8'hA5 MSB first, strobes spaced 4 clk
    sel = 0;
    cyc();
    do_reset();
    chk_idle_outputs("t1_reset");
    push_word(16'h00A5, 8, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      cyc(3);
      strobe($sformatf("t1_s%0d", i), i <= 8, i == 9, i <= 8 ? i : 0);
      if (i == 9) begin
        cyc();
        chk("t1_wd_one_clk", 16'(o_wd), 16'h0);
      end
    end

    // 2: LSB-first build, 8'h01
    sel = 1;
    do_reset();
    chk_idle_outputs("t2_reset");
    push_word(16'h0001, 8, 1'b0, 1'b1);
    cyc(2);
    for (int i = 1; i <= 9; i++) strobe($sformatf("t2_s%0d", i), i <= 8, i == 9, i <= 8 ? i : 0);

    // 3: two words back-to-back without a gap bit
    sel = 0;
    do_reset();
    push_word(16'h003C, 8, 1'b1, 1'b1);
    cyc(2);
    strobe("t3_s1", 1'b1, 1'b0, 1);
    push_word(16'h00C3, 8, 1'b1, 1'b1);
    chk("t3_ready_held", 16'(o_ready), 16'h0);
    for (int i = 2; i <= 17; i++) begin
      strobe($sformatf("t3_s%0d", i), i <= 16, i == 9 || i == 17, i <= 8 ? i : (i <= 16 ? i - 8 : 0));
      if (i == 8) chk("t3_ready_before_reload", 16'(o_ready), 16'h0);
      if (i == 9) chk("t3_ready_after_reload", 16'(o_ready), 16'h1);
    end

    // 4: enable gating at start and at the word boundary
    do_reset();
    enable = 1'b0;
    push_word(16'h00AA, 8, 1'b1, 1'b1);
    cyc(3);
    chk("t4_ready_blocked", 16'(o_ready), 16'h0);
    strobe("t4_ign1", 1'b0, 1'b0, 0);
    strobe("t4_ign2", 1'b0, 1'b0, 0);
    enable = 1'b1;
    cyc(2);
    strobe("t4_s1", 1'b1, 1'b0, 1);
    enable = 1'b0;
    push_word(16'h0055, 8, 1'b1, 1'b0);
    for (int i = 2; i <= 9; i++) strobe($sformatf("t4_s%0d", i), i <= 8, i == 9, i <= 8 ? i : 0);
    strobe("t4_after", 1'b0, 1'b0, 0);
    chk("t4_hold_kept", 16'(o_ready), 16'h0);

    // 5: reset mid-word with a word waiting in hold
    enable = 1'b1;
    do_reset();
    push_word(16'h000F, 8, 1'b1, 1'b1);
    cyc(2);
    for (int i = 1; i <= 3; i++) strobe($sformatf("t5_s%0d", i), 1'b1, 1'b0, i);
    push_word(16'h00F0, 8, 1'b1, 1'b0);
    do_reset();
    chk_idle_outputs("t5_reset");
    cyc(3);
    strobe("t5_dead1", 1'b0, 1'b0, 0);
    strobe("t5_dead2", 1'b0, 1'b0, 0);

    // 6: 16-bit build, 16'hBEEF
    sel = 2;
    do_reset();
    chk_idle_outputs("t6_reset");
    push_word(16'hBEEF, 16, 1'b1, 1'b1);
    cyc(2);
    for (int i = 1; i <= 17; i++) strobe($sformatf("t6_s%0d", i), i <= 16, i == 17, i <= 16 ? i : 0);
    chk("t6_queue_drained", 16'(exp_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
